rotor_sequencer: RTL
====================

# rotor_sequencer

Per-character controller for a cascade of `NUM_ROTORS` rotor stages in the enigma datapath. It accepts ASCII characters over a valid/ready handshake and issues odometer-style stepping pulses (`rot_en`) to the rotors. It then routes each character serially through every rotor using that rotor's `valid`/`done` handshake, and returns the result over a second valid/ready handshake. It also issues the configuration-load strobe (`rot_set`) to all rotors. It sits between the host character interface and the rotor instances.

## Interface
- `NUM_ROTORS`, 3: number of rotor stages sequenced (1..8).
- `TIMEOUT_CYCLES`, 255: watchdog limit per stage. Used only with `ROTOR_SEQ_TIMEOUT_EN`.
- `clk` in 1: the only clock. Everything is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `cfg_load` in 1: pulse that loads the configuration. Honoured only in IDLE.
- `cfg_dec` in 1: mode, sampled on an accepted `cfg_load`. 0 = encode, 1 = decode.
- `char_valid` in 1, `char_in` in 8: input character.
- `char_ready` out 1: input handshake ready.
- `out_valid` out 1, `out_char` out 8: result character.
- `out_ready` in 1: output handshake ready.
- `busy` out 1: high in any state other than IDLE.
- `err` out 1: stage timeout flag, one pulse with `out_valid`.
- `rot_set` out `NUM_ROTORS`: config strobe to each rotor.
- `rot_en` out `NUM_ROTORS`: step pulse to each rotor.
- `rot_valid` out `NUM_ROTORS`: per-rotor input strobe.
- `rot_din` out 8: shared input data bus to all rotors.
- `rot_dec` out 1: direction to all rotors.
- `rot_dout` in 8×`NUM_ROTORS`: rotor k output on bits [8k+7:8k].
- `rot_done` in `NUM_ROTORS`: per-rotor one-cycle completion pulse.

## Operation
- **States:** IDLE, CFG, STEP, ISSUE, WAIT, OUT.
- **IDLE:**
  - `cfg_load` has priority and moves to CFG.
  - Otherwise, when `char_valid && char_ready`, latch `char_in` into the working register.
  - A letter ('A'..'Z', 65..90) moves to STEP. Any other byte moves directly to OUT unchanged, with no rotor activity.
- **CFG:**
  - `rot_set` is all ones for exactly one cycle.
  - Latch `cfg_dec` into `rot_dec`.
  - Clear all step counters to 0.
  - Return to IDLE.
- **STEP (one cycle, odometer stepping):**
  - `rot_en[0]` = 1.
  - `rot_en[k]` = `rot_en[k-1]` AND (`step_cnt[k-1]` == 25), using counter values from before the update.
  - Each stepped counter increments modulo 26 (25 wraps to 0).
  - Stepping is identical in both modes; the rotors apply direction themselves.
- **Stage order:** encode visits rotors 0..N-1; decode visits rotors N-1..0.
- **ISSUE:**
  - `rot_din` = working register.
  - `rot_valid` is one-hot on the current stage for one cycle.
  - Go to WAIT.
- **WAIT:**
  - `rot_din` holds its value.
  - On `rot_done` of the current stage, latch that stage's `rot_dout` into the working register.
  - If that was the last stage, go to OUT; otherwise go to ISSUE for the next stage.
  - `rot_done` from a non-current stage is ignored.
- **OUT:**
  - `out_valid` = 1 and `out_char` = working register, both held stable until `out_ready`.
  - On `out_ready`, go to IDLE.
- `char_ready` = (state == IDLE) AND NOT `cfg_load` AND NOT `reset`.

## Timing
- Reset values:
  - All outputs are 0, including `rot_dec`, `out_char` and `char_ready`.
  - State is IDLE and step counters are 0.
  - `char_ready` rises on the first cycle after `reset` falls.
- Reset mid-character: the character is dropped, no output is produced, and rotor strobes drop immediately.
- Letter latency, with accept at cycle 0 and L_k = cycles from `rot_valid` to `rot_done` for stage k:
  - STEP at cycle 1.
  - First ISSUE at cycle 2.
  - `out_valid` first high at cycle 2 + N + ΣL_k.
- Non-letter latency: `out_valid` high at cycle 1.
- `out_ready` already high when `out_valid` rises: the transfer completes in one cycle and IDLE follows next cycle.
- Throughput: at most one character in flight.
- `cfg_load` outside IDLE is ignored and not queued.

## Configuration
- **`ROTOR_SEQ_TIMEOUT_EN` defined:**
  - An 8-bit-or-wider counter restarts on each ISSUE.
  - If the counter reaches `TIMEOUT_CYCLES` in WAIT with no `rot_done`, abort the remaining stages and go to OUT with `out_char` = 8'h3F ('?') and `err` = 1 for the OUT beat.
  - Step counters keep the step already applied.
- **Undefined:** WAIT waits indefinitely and `err` is tied to 0.

## Structure
- **`rotor_seq_pkg`** holds:
  - the state enum;
  - `LETTER_A` = 65, `LETTER_Z` = 90, `ALPHABET` = 26;
  - `TIMEOUT_CHAR` = 8'h3F.
- **Sub-module `rotor_step_ctr`** holds the `NUM_ROTORS` modulo-26 counters. It has inputs clear and step, and outputs the `rot_en` vector.

## Test plan
Stub rotors: `done` pulses 2 cycles after `valid`, and `dout` = `din` + 1.
- **Reset and config:** reset, release, pulse `cfg_load` with `cfg_dec`=0 → all outputs 0 during reset, `char_ready`=1 after release, `rot_set`=3'b111 for exactly one cycle, `char_ready`=0 during CFG.
- **Encode 'A' (0x41):**
  - `rot_en`=3'b001 at cycle 1.
  - `rot_valid` order 001, 010, 100.
  - `out_valid` at cycle 11, `out_char`=0x44.
  - Holding `out_ready`=0 for 5 cycles keeps `out_char` stable.
- **Odometer:**
  - Characters 1..25 give `rot_en`=3'b001.
  - Character 26 gives 3'b011.
  - Character 676 gives 3'b111.
  - Character 677 gives 3'b001.
- **Decode mode:** `cfg_load` with `cfg_dec`=1, send 'A' → `rot_dec`=1, `rot_valid` order 100, 010, 001, `out_char`=0x44.
- **Non-letter:** send 0x35 → `out_valid` at cycle 1 with 0x35, no `rot_en` or `rot_valid` activity, step counters unchanged.
- **Timeout (macro defined, `TIMEOUT_CYCLES`=255):** stage 1 never asserts `done` → `out_char`=0x3F and `err`=1, stage 2 is never issued, next letter is accepted normally.

Source files
------------

// File: rtl/rotor_sequencer_pkg.sv
// Shared state encoding, alphabet constants and helpers for the rotor sequencer.
package rotor_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_STEP  = 3'd2,
    S_ISSUE = 3'd3,
    S_WAIT  = 3'd4,
    S_OUT   = 3'd5
  } seq_state_t;

  localparam int LETTER_A = 65;
  localparam int LETTER_Z = 90;
  localparam int ALPHABET = 26;
  localparam logic [7:0] TIMEOUT_CHAR = 8'h3F;

  function automatic logic is_letter(input logic [7:0] c);
    return (c >= 8'(LETTER_A)) && (c <= 8'(LETTER_Z));
  endfunction

endpackage

// File: rtl/rotor_sequencer_step_ctr.sv
// Odometer-style modulo-26 step counters; rot_en ripples a carry from rotor 0 upwards.
module rotor_step_ctr
  import rotor_seq_pkg::*;
#(
  parameter int NUM_ROTORS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  step,
  output logic [NUM_ROTORS-1:0] rot_en
);

  localparam logic [4:0] LAST_POS = 5'(ALPHABET - 1);

  logic [4:0] cnt_r [NUM_ROTORS];

  // Carry chain uses counter values from before this cycle's update
  always_comb begin
    logic carry_s;
    rot_en  = '0;
    carry_s = step;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      rot_en[k] = carry_s;
      carry_s   = carry_s && (cnt_r[k] == LAST_POS);
    end
  end

  // Counter update: clear on config load, otherwise advance each stepped rotor
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NUM_ROTORS; k++) cnt_r[k] <= 5'd0;
    end else if (clear) begin
      for (int k = 0; k < NUM_ROTORS; k++) cnt_r[k] <= 5'd0;
    end else begin
      for (int k = 0; k < NUM_ROTORS; k++) begin
        if (rot_en[k]) cnt_r[k] <= (cnt_r[k] == LAST_POS) ? 5'd0 : cnt_r[k] + 5'd1;
      end
    end
  end

endmodule

// File: rtl/rotor_sequencer.sv
// Per-character rotor cascade controller: steps rotors, routes a letter through each stage.
// Optional stage watchdog enabled by defining ROTOR_SEQ_TIMEOUT_EN.
module rotor_sequencer
  import rotor_seq_pkg::*;
#(
  parameter int NUM_ROTORS     = 3,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cfg_load,
  input  logic                    cfg_dec,
  input  logic                    char_valid,
  input  logic [7:0]              char_in,
  output logic                    char_ready,
  output logic                    out_valid,
  output logic [7:0]              out_char,
  input  logic                    out_ready,
  output logic                    busy,
  output logic                    err,
  output logic [NUM_ROTORS-1:0]   rot_set,
  output logic [NUM_ROTORS-1:0]   rot_en,
  output logic [NUM_ROTORS-1:0]   rot_valid,
  output logic [7:0]              rot_din,
  output logic                    rot_dec,
  input  logic [8*NUM_ROTORS-1:0] rot_dout,
  input  logic [NUM_ROTORS-1:0]   rot_done
);

`ifdef ROTOR_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int WDW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [2:0] LAST_IDX = 3'(NUM_ROTORS - 1);

  seq_state_t            state_r, state_s;
  logic [7:0]            work_r, work_s;
  logic                  dec_r, dec_s;
  logic                  err_r, err_s;
  logic [2:0]            cur_r, cur_s;
  logic [WDW-1:0]        wd_r, wd_s;
  logic [NUM_ROTORS-1:0] sel_s;
  logic [7:0]            dout_s;
  logic                  done_s, last_s, timeout_s;

  // Current-stage one-hot select and result mux
  always_comb begin
    sel_s  = '0;
    dout_s = 8'h00;
    for (int k = 0; k < NUM_ROTORS; k++) begin
      if (cur_r == 3'(k)) begin
        sel_s[k] = 1'b1;
        dout_s   = rot_dout[8*k +: 8];
      end else begin
        sel_s[k] = 1'b0;
      end
    end
  end

  assign done_s    = |(rot_done & sel_s);
  assign last_s    = dec_r ? (cur_r == 3'd0) : (cur_r == LAST_IDX);
  assign timeout_s = TIMEOUT_EN && (wd_r == WDW'(TIMEOUT_CYCLES));

  // Next-state and working-register updates
  always_comb begin
    state_s = state_r;
    work_s  = work_r;
    dec_s   = dec_r;
    err_s   = err_r;
    cur_s   = cur_r;
    wd_s    = wd_r;
    case (state_r)
      S_IDLE: begin
        if (cfg_load) begin
          dec_s   = cfg_dec;
          state_s = S_CFG;
        end else if (char_valid) begin
          work_s  = char_in;
          err_s   = 1'b0;
          state_s = is_letter(char_in) ? S_STEP : S_OUT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CFG:  state_s = S_IDLE;
      S_STEP: begin
        cur_s   = dec_r ? LAST_IDX : 3'd0;
        state_s = S_ISSUE;
      end
      S_ISSUE: begin
        wd_s    = '0;
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (done_s) begin
          work_s = dout_s;
          if (last_s) begin
            state_s = S_OUT;
          end else begin
            cur_s   = dec_r ? cur_r - 3'd1 : cur_r + 3'd1;
            state_s = S_ISSUE;
          end
        end else if (timeout_s) begin
          // Abandon the remaining stages; steps already applied stay applied
          work_s  = TIMEOUT_CHAR;
          err_s   = 1'b1;
          state_s = S_OUT;
        end else begin
          wd_s = wd_r + WDW'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          err_s   = 1'b0;
          state_s = S_IDLE;
        end else begin
          state_s = S_OUT;
        end
      end
      default: state_s = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_IDLE;
      work_r  <= 8'h00;
      dec_r   <= 1'b0;
      err_r   <= 1'b0;
      cur_r   <= 3'd0;
      wd_r    <= '0;
    end else begin
      state_r <= state_s;
      work_r  <= work_s;
      dec_r   <= dec_s;
      err_r   <= err_s;
      cur_r   <= cur_s;
      wd_r    <= wd_s;
    end
  end

  rotor_step_ctr #(.NUM_ROTORS(NUM_ROTORS)) u_step_ctr (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_r == S_CFG),
    .step   (state_r == S_STEP),
    .rot_en (rot_en)
  );

  assign char_ready = (state_r == S_IDLE) && !cfg_load && !reset;
  assign busy       = (state_r != S_IDLE);
  assign out_valid  = (state_r == S_OUT);
  assign out_char   = (state_r == S_OUT) ? work_r : 8'h00;
  assign err        = TIMEOUT_EN && (state_r == S_OUT) && err_r;
  assign rot_set    = {NUM_ROTORS{state_r == S_CFG}};
  assign rot_valid  = (state_r == S_ISSUE) ? sel_s : '0;
  assign rot_din    = ((state_r == S_ISSUE) || (state_r == S_WAIT)) ? work_r : 8'h00;
  assign rot_dec    = dec_r;

endmodule
